ghost_nav: RTL and testbench
============================

GHOST_NAV -- requirements
Module: ghost_nav

Interface
REQ-001 SHALL have parameter COORD_W, default 8, tile-coordinate width.
REQ-002 SHALL have parameter MAP_W, default 28, map width in tiles; x wraps modulo MAP_W.
REQ-003 SHALL have parameter PERSONALITY, default 2, target rule: 0 Blinky, 1 Pinky, 2 Inky, 3 Clyde.
REQ-004 SHALL have parameters SCATTER_X/SCATTER_Y, default 0/0, scatter corner; HOME_X/HOME_Y, default 13/14, ghost-house target.
REQ-005 SHALL have parameter LFSR_SEED, default 16'hACE1, frightened-mode generator seed.
REQ-006 Ports:
 sysclk  in  1  single clock, all logic on posedge.
 resetn  in  1  synchronous, active-low reset.
 start  in  1  one-cycle request to compute one move.
 busy  out  1  high from the cycle after an accepted start through done.
 done  out  1  one-cycle pulse; next_* valid from this cycle.
 pac_x, pac_y  in  COORD_W  Pac-Man tile.
 pac_dir  in  2  Pac-Man facing.
 blinky_x, blinky_y  in  COORD_W  Blinky tile (Inky rule only).
 cur_x, cur_y  in  COORD_W  ghost tile.
 cur_dir  in  2  ghost facing.
 mode  in  4  one-hot: [3] chase, [2] scatter, [1] frightened, [0] eaten.
 reverse  in  1  request reversal on this move.
 rom_addr  out  16  wall-ROM address = cur_y*MAP_W + cur_x.
 rom_data  in  4  clear bits {left,right,up,down}, valid one cycle after rom_addr.
 next_x, next_y  out  COORD_W  new tile.
 next_dir  out  2  new facing.

Function
REQ-007 Direction code SHALL be 0 UP, 1 LEFT, 2 DOWN, 3 RIGHT; opposite = code XOR 2.
REQ-008 start SHALL be accepted only in IDLE; all inputs except rom_data SHALL be registered on acceptance; start while busy SHALL be ignored.
REQ-009 FSM SHALL be IDLE -> FETCH -> WAIT -> TARGET -> DIST -> SELECT -> DONE -> IDLE, one cycle per state; done SHALL assert exactly 6 cycles after the accepting edge.
REQ-010 FETCH SHALL drive rom_addr; WAIT SHALL capture rom_data.
REQ-011 Candidates SHALL be clear directions excluding opposite(cur_dir); with reverse=1, the only candidate SHALL be opposite(cur_dir).
REQ-012 Chase targets: Blinky = pac; Pinky = pac + 4 tiles ahead; Inky = 2*(pac + 2 ahead) - blinky; Clyde = pac if squared distance >= 64, else scatter corner.
REQ-013 Target arithmetic SHALL be signed, COORD_W+2 bits; results SHALL be clamped to [0, 2^COORD_W-1].
REQ-014 Scatter SHALL target (SCATTER_X,SCATTER_Y); eaten SHALL target (HOME_X,HOME_Y).
REQ-015 DIST SHALL compute squared Euclidean distance from each candidate's neighbour tile to target, 2*COORD_W+3 bits unsigned; non-candidates SHALL be forced to all-ones.
REQ-016 SELECT SHALL pick minimum distance; ties SHALL resolve UP > LEFT > DOWN > RIGHT.
REQ-017 Frightened SHALL ignore distances: LFSR[1:0] selects a preferred direction; if not a candidate, the first candidate in tie-break order SHALL be used.
REQ-018 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance once per accepted start.
REQ-019 No candidate SHALL yield next = cur position, next_dir = cur_dir.
REQ-020 Moves: LEFT x-1, RIGHT x+1, UP y-1, DOWN y+1; x SHALL wrap (0 LEFT -> MAP_W-1; MAP_W-1 RIGHT -> 0); y SHALL NOT wrap.
REQ-021 mode not one-hot SHALL be treated as scatter.
REQ-022 next_* SHALL hold until the next DONE.

Reset
REQ-023 resetn=0 at a posedge SHALL force IDLE, busy=0, done=0, rom_addr=0, next_x=0, next_y=0, next_dir=LEFT, LFSR=LFSR_SEED.
REQ-024 Reset mid-operation SHALL abort without a done pulse; start during reset SHALL be ignored.

Structure
REQ-025 Package ghost_pkg SHALL hold direction codes, mode one-hot constants, personality codes and the opposite-direction function.
REQ-026 Target computation SHALL live in sub-module ghost_target (combinational, parametrised by PERSONALITY, COORD_W).

Verification
REQ-027 Inky chase, pac (10,10) facing RIGHT, blinky (8,10), ghost (5,5) facing RIGHT, rom 4'b1111 -> target (16,10), next (6,5) dir RIGHT, done 6 cycles after start.
REQ-028 Tie: target straight above, rom 4'b1111, cur_dir DOWN -> UP excluded; LEFT and RIGHT equidistant -> next_dir LEFT.
REQ-029 Tunnel: cur (0,14) facing LEFT, rom 4'b1000, scatter -> next (27,14) dir LEFT.
REQ-030 reverse=1, cur_dir LEFT, rom 4'b0100 -> next_dir RIGHT; rom 4'b0000 -> position and dir unchanged.
REQ-031 Frightened, reset then 4 starts -> next_dir sequence matches golden LFSR model from 16'hACE1.
REQ-032 resetn low during DIST -> no done pulse, outputs at reset values; start during busy -> ignored, single done.

Source files
------------

// File: rtl/ghost_pkg.sv
// Shared types and helpers for the ghost navigation block: direction codes,
// mode one-hot constants, personality codes and FSM state encoding.
package ghost_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam logic [3:0] MODE_CHASE   = 4'b1000;
  localparam logic [3:0] MODE_SCATTER = 4'b0100;
  localparam logic [3:0] MODE_FRIGHT  = 4'b0010;
  localparam logic [3:0] MODE_EATEN   = 4'b0001;

  localparam int PERS_BLINKY = 0;
  localparam int PERS_PINKY  = 1;
  localparam int PERS_INKY   = 2;
  localparam int PERS_CLYDE  = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_TARGET = 3'd3,
    S_DIST   = 3'd4,
    S_SELECT = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

  // Anything that is not exactly one-hot falls back to scatter.
  function automatic logic [3:0] norm_mode(input logic [3:0] m);
    case (m)
      MODE_CHASE, MODE_SCATTER, MODE_FRIGHT, MODE_EATEN: return m;
      default: return MODE_SCATTER;
    endcase
  endfunction

endpackage

// File: rtl/ghost_target.sv
// Combinational target-tile selection for one ghost personality.
// Arithmetic is signed COORD_W+2 bits; the result is clamped to the tile range.
module ghost_target
  import ghost_pkg::*;
#(
  parameter int COORD_W     = 8,
  parameter int PERSONALITY = PERS_INKY,
  parameter int SCATTER_X   = 0,
  parameter int SCATTER_Y   = 0,
  parameter int HOME_X      = 13,
  parameter int HOME_Y      = 14
) (
  input  logic [3:0]         mode,
  input  logic [COORD_W-1:0] pac_x,
  input  logic [COORD_W-1:0] pac_y,
  input  logic [1:0]         pac_dir,
  input  logic [COORD_W-1:0] blinky_x,
  input  logic [COORD_W-1:0] blinky_y,
  input  logic [COORD_W-1:0] cur_x,
  input  logic [COORD_W-1:0] cur_y,
  output logic [COORD_W-1:0] tgt_x,
  output logic [COORD_W-1:0] tgt_y
);

  localparam int SW = COORD_W + 2;
  localparam int WW = 2 * SW;
  localparam logic signed [SW-1:0] CMAX = SW'((1 << COORD_W) - 1);

  function automatic logic signed [SW-1:0] sx(input logic [COORD_W-1:0] v);
    return $signed({2'b00, v});
  endfunction

  function automatic logic [COORD_W-1:0] clamp(input logic signed [SW-1:0] v);
    if (v < 0) return '0;
    if (v > CMAX) return '1;
    return v[COORD_W-1:0];
  endfunction

  logic signed [SW-1:0] px, py, ux, uy, rx, ry, dx, dy;
  logic signed [WW-1:0] dxw, dyw, d2;

  always_comb begin
    px = sx(pac_x);
    py = sx(pac_y);
    ux = '0;
    uy = '0;
    case (dir_e'(pac_dir))
      DIR_UP:    uy = '1;
      DIR_LEFT:  ux = '1;
      DIR_DOWN:  uy = SW'(1);
      DIR_RIGHT: ux = SW'(1);
      default: ;
    endcase
    dx  = px - sx(cur_x);
    dy  = py - sx(cur_y);
    dxw = WW'(dx);
    dyw = WW'(dy);
    d2  = dxw * dxw + dyw * dyw;

    rx = px;
    ry = py;
    if (mode == MODE_EATEN) begin
      rx = SW'(HOME_X);
      ry = SW'(HOME_Y);
    end else if (mode == MODE_CHASE) begin
      case (PERSONALITY)
        PERS_PINKY: begin
          rx = px + (ux <<< 2);
          ry = py + (uy <<< 2);
        end
        PERS_INKY: begin
          rx = ((px + (ux <<< 1)) <<< 1) - sx(blinky_x);
          ry = ((py + (uy <<< 1)) <<< 1) - sx(blinky_y);
        end
        PERS_CLYDE: begin
          if (d2 < 64) begin
            rx = SW'(SCATTER_X);
            ry = SW'(SCATTER_Y);
          end
        end
        default: ;
      endcase
    end else if (mode != MODE_FRIGHT) begin
      rx = SW'(SCATTER_X);
      ry = SW'(SCATTER_Y);
    end
    tgt_x = clamp(rx);
    tgt_y = clamp(ry);
  end

endmodule

// File: rtl/ghost_nav.sv
// Ghost move engine: fetches walls for the current tile, picks a target and
// chooses the next tile/direction, one FSM state per cycle.
//
//   state  | meaning
//   IDLE   | waiting for start; inputs latched and LFSR stepped on accept
//   FETCH  | rom_addr presented to the wall ROM
//   WAIT   | rom_data captured, remapped to direction order
//   TARGET | target tile and candidate mask registered
//   DIST   | squared distance per candidate neighbour registered
//   SELECT | winner chosen, next_* registered
//   DONE   | done pulse, next_* valid
module ghost_nav
  import ghost_pkg::*;
#(
  parameter int          COORD_W     = 8,
  parameter int          MAP_W       = 28,
  parameter int          PERSONALITY = 2,
  parameter int          SCATTER_X   = 0,
  parameter int          SCATTER_Y   = 0,
  parameter int          HOME_X      = 13,
  parameter int          HOME_Y      = 14,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic               sysclk,
  input  logic               resetn,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic [COORD_W-1:0] pac_x,
  input  logic [COORD_W-1:0] pac_y,
  input  logic [1:0]         pac_dir,
  input  logic [COORD_W-1:0] blinky_x,
  input  logic [COORD_W-1:0] blinky_y,
  input  logic [COORD_W-1:0] cur_x,
  input  logic [COORD_W-1:0] cur_y,
  input  logic [1:0]         cur_dir,
  input  logic [3:0]         mode,
  input  logic               reverse,
  output logic [15:0]        rom_addr,
  input  logic [3:0]         rom_data,
  output logic [COORD_W-1:0] next_x,
  output logic [COORD_W-1:0] next_y,
  output logic [1:0]         next_dir
);

  localparam int SW = COORD_W + 2;
  localparam int DW = 2 * COORD_W + 3;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(MAP_W - 1);

  function automatic logic [DW-1:0] dist_sq(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                                            input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by);
    logic signed [SW-1:0] dx, dy;
    logic signed [DW-1:0] ex, ey;
    dx = $signed({2'b00, ax}) - $signed({2'b00, bx});
    dy = $signed({2'b00, ay}) - $signed({2'b00, by});
    ex = DW'(dx);
    ey = DW'(dy);
    return $unsigned(ex * ex + ey * ey);
  endfunction

  state_e state_q, state_d;
  logic [COORD_W-1:0] pac_x_q, pac_x_d, pac_y_q, pac_y_d;
  logic [COORD_W-1:0] blinky_x_q, blinky_x_d, blinky_y_q, blinky_y_d;
  logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [1:0]         pac_dir_q, pac_dir_d, cur_dir_q, cur_dir_d;
  logic [3:0]         mode_q, mode_d;
  logic               reverse_q, reverse_d;
  logic [3:0]         clear_q, clear_d;
  logic [3:0]         cand_q, cand_d;
  logic [COORD_W-1:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [3:0][DW-1:0] dist_q, dist_d;
  logic [15:0]        rom_addr_q, rom_addr_d;
  logic [COORD_W-1:0] next_x_q, next_x_d, next_y_q, next_y_d;
  logic [1:0]         next_dir_q, next_dir_d;
  logic [15:0]        lfsr_q, lfsr_d;

  logic [COORD_W-1:0] tgt_x_w, tgt_y_w;
  logic [3:0][COORD_W-1:0] nbr_x, nbr_y;
  logic [1:0]         pick;
  logic               found;
  logic [DW-1:0]      best;
  dir_e               opp;

  ghost_target #(
    .COORD_W     (COORD_W),
    .PERSONALITY (PERSONALITY),
    .SCATTER_X   (SCATTER_X),
    .SCATTER_Y   (SCATTER_Y),
    .HOME_X      (HOME_X),
    .HOME_Y      (HOME_Y)
  ) u_target (
    .mode     (mode_q),
    .pac_x    (pac_x_q),
    .pac_y    (pac_y_q),
    .pac_dir  (pac_dir_q),
    .blinky_x (blinky_x_q),
    .blinky_y (blinky_y_q),
    .cur_x    (cur_x_q),
    .cur_y    (cur_y_q),
    .tgt_x    (tgt_x_w),
    .tgt_y    (tgt_y_w)
  );

  // x wraps through the tunnel; y saturates at the map edge.
  always_comb begin
    for (int d = 0; d < 4; d++) begin
      nbr_x[d] = cur_x_q;
      nbr_y[d] = cur_y_q;
      case (2'(d))
        DIR_UP:    nbr_y[d] = (cur_y_q == '0) ? cur_y_q : cur_y_q - COORD_W'(1);
        DIR_LEFT:  nbr_x[d] = (cur_x_q == '0) ? X_LAST : cur_x_q - COORD_W'(1);
        DIR_DOWN:  nbr_y[d] = (cur_y_q == '1) ? cur_y_q : cur_y_q + COORD_W'(1);
        DIR_RIGHT: nbr_x[d] = (cur_x_q >= X_LAST) ? '0 : cur_x_q + COORD_W'(1);
        default: ;
      endcase
    end
  end

  // Scanning in code order gives the UP > LEFT > DOWN > RIGHT tie-break.
  always_comb begin
    pick  = 2'd0;
    found = 1'b0;
    best  = '1;
    if (mode_q == MODE_FRIGHT) begin
      if (cand_q[lfsr_q[1:0]]) begin
        pick = lfsr_q[1:0];
      end else begin
        for (int d = 0; d < 4; d++) begin
          if (cand_q[d] && !found) begin
            pick  = 2'(d);
            found = 1'b1;
          end
        end
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (cand_q[d] && (!found || dist_q[d] < best)) begin
          pick  = 2'(d);
          best  = dist_q[d];
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pac_x_d    = pac_x_q;
    pac_y_d    = pac_y_q;
    pac_dir_d  = pac_dir_q;
    blinky_x_d = blinky_x_q;
    blinky_y_d = blinky_y_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    cur_dir_d  = cur_dir_q;
    mode_d     = mode_q;
    reverse_d  = reverse_q;
    clear_d    = clear_q;
    cand_d     = cand_q;
    tgt_x_d    = tgt_x_q;
    tgt_y_d    = tgt_y_q;
    dist_d     = dist_q;
    rom_addr_d = rom_addr_q;
    next_x_d   = next_x_q;
    next_y_d   = next_y_q;
    next_dir_d = next_dir_q;
    lfsr_d     = lfsr_q;
    opp        = opposite(dir_e'(cur_dir_q));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          pac_x_d    = pac_x;
          pac_y_d    = pac_y;
          pac_dir_d  = pac_dir;
          blinky_x_d = blinky_x;
          blinky_y_d = blinky_y;
          cur_x_d    = cur_x;
          cur_y_d    = cur_y;
          cur_dir_d  = cur_dir;
          mode_d     = norm_mode(mode);
          reverse_d  = reverse;
          rom_addr_d = 16'(cur_y) * 16'(MAP_W) + 16'(cur_x);
          lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        state_d = S_TARGET;
        // ROM order {left,right,up,down} -> direction-code order {R,D,L,U}
        clear_d = {rom_data[2], rom_data[0], rom_data[3], rom_data[1]};
      end
      S_TARGET: begin
        state_d = S_DIST;
        tgt_x_d = tgt_x_w;
        tgt_y_d = tgt_y_w;
        if (reverse_q) cand_d = clear_q[opp] ? (4'b0001 << opp) : 4'b0000;
        else           cand_d = clear_q & ~(4'b0001 << opp);
      end
      S_DIST: begin
        state_d = S_SELECT;
        for (int d = 0; d < 4; d++) begin
          dist_d[d] = cand_q[d] ? dist_sq(nbr_x[d], nbr_y[d], tgt_x_q, tgt_y_q) : '1;
        end
      end
      S_SELECT: begin
        state_d = S_DONE;
        if (cand_q != 4'b0000) begin
          next_x_d   = nbr_x[pick];
          next_y_d   = nbr_y[pick];
          next_dir_d = pick;
        end else begin
          next_x_d   = cur_x_q;
          next_y_d   = cur_y_q;
          next_dir_d = cur_dir_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      pac_x_q    <= '0;
      pac_y_q    <= '0;
      pac_dir_q  <= '0;
      blinky_x_q <= '0;
      blinky_y_q <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      cur_dir_q  <= '0;
      mode_q     <= MODE_SCATTER;
      reverse_q  <= 1'b0;
      clear_q    <= '0;
      cand_q     <= '0;
      tgt_x_q    <= '0;
      tgt_y_q    <= '0;
      dist_q     <= '1;
      rom_addr_q <= '0;
      next_x_q   <= '0;
      next_y_q   <= '0;
      next_dir_q <= DIR_LEFT;
      lfsr_q     <= LFSR_SEED;
    end else begin
      state_q    <= state_d;
      pac_x_q    <= pac_x_d;
      pac_y_q    <= pac_y_d;
      pac_dir_q  <= pac_dir_d;
      blinky_x_q <= blinky_x_d;
      blinky_y_q <= blinky_y_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      cur_dir_q  <= cur_dir_d;
      mode_q     <= mode_d;
      reverse_q  <= reverse_d;
      clear_q    <= clear_d;
      cand_q     <= cand_d;
      tgt_x_q    <= tgt_x_d;
      tgt_y_q    <= tgt_y_d;
      dist_q     <= dist_d;
      rom_addr_q <= rom_addr_d;
      next_x_q   <= next_x_d;
      next_y_q   <= next_y_d;
      next_dir_q <= next_dir_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign rom_addr = rom_addr_q;
  assign next_x   = next_x_q;
  assign next_y   = next_y_q;
  assign next_dir = next_dir_q;

endmodule

// File: tb/tb_ghost_nav.sv
// Directed bench for ghost_nav: hand-computed moves, tie-break, tunnel wrap,
// reversal, frightened LFSR sequence, mid-operation reset and start-while-busy.
module tb_ghost_nav;

  logic        sysclk, resetn, start, busy, done, reverse;
  logic [7:0]  pac_x, pac_y, blinky_x, blinky_y, cur_x, cur_y, next_x, next_y;
  logic [1:0]  pac_dir, cur_dir, next_dir;
  logic [3:0]  mode, rom_data;
  logic [15:0] rom_addr;

  int errors = 0;
  int checks = 0;

  ghost_nav u_dut (
    .sysclk   (sysclk),
    .resetn   (resetn),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pac_x    (pac_x),
    .pac_y    (pac_y),
    .pac_dir  (pac_dir),
    .blinky_x (blinky_x),
    .blinky_y (blinky_y),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .cur_dir  (cur_dir),
    .mode     (mode),
    .reverse  (reverse),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .next_x   (next_x),
    .next_y   (next_y),
    .next_dir (next_dir)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run_move(input string tag, input logic [7:0] ex_x, input logic [7:0] ex_y,
                          input logic [1:0] ex_dir);
    int k;
    logic [15:0] ex_addr;
    ex_addr = 16'(cur_y) * 16'd28 + 16'(cur_x);
    @(negedge sysclk); start = 1'b1;
    @(negedge sysclk); start = 1'b0; k = 1;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " rom_addr"}, 32'(rom_addr), 32'(ex_addr));
    while (done !== 1'b1 && k < 12) begin
      @(negedge sysclk); k++;
    end
    chk({tag, " done_seen"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(k), 32'd6);
    chk({tag, " next_x"}, 32'(next_x), 32'(ex_x));
    chk({tag, " next_y"}, 32'(next_y), 32'(ex_y));
    chk({tag, " next_dir"}, 32'(next_dir), 32'(ex_dir));
    @(negedge sysclk);
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  initial begin
    logic [15:0] gold;
    logic [1:0]  pref, exd;
    logic [7:0]  exx, exy;
    int n_done, first_k;

    resetn = 1'b0; start = 1'b0; reverse = 1'b0;
    pac_x = 8'd0; pac_y = 8'd0; pac_dir = 2'd0;
    blinky_x = 8'd0; blinky_y = 8'd0;
    cur_x = 8'd0; cur_y = 8'd0; cur_dir = 2'd0;
    mode = 4'b0100; rom_data = 4'b0000;

    // reset state, with start asserted during reset
    repeat (2) @(negedge sysclk);
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst rom_addr", 32'(rom_addr), 32'd0);
    chk("rst next_x", 32'(next_x), 32'd0);
    chk("rst next_y", 32'(next_y), 32'd0);
    chk("rst next_dir", 32'(next_dir), 32'd1);
    resetn = 1'b1;
    @(negedge sysclk);
    chk("start_in_reset ignored", 32'(busy), 32'd0);

    // Inky chase: target (16,10), RIGHT neighbour (6,5) is closest
    pac_x = 8'd10; pac_y = 8'd10; pac_dir = 2'd3;
    blinky_x = 8'd8; blinky_y = 8'd10;
    cur_x = 8'd5; cur_y = 8'd5; cur_dir = 2'd3;
    mode = 4'b1000; rom_data = 4'b1111;
    run_move("inky", 8'd6, 8'd5, 2'd3);
    chk("inky tgt_x", 32'(u_dut.tgt_x_q), 32'd16);
    chk("inky tgt_y", 32'(u_dut.tgt_y_q), 32'd10);

    // eaten: home (13,14) straight above (13,20); UP excluded, LEFT/RIGHT tie -> LEFT
    mode = 4'b0001; cur_x = 8'd13; cur_y = 8'd20; cur_dir = 2'd2;
    run_move("tie", 8'd12, 8'd20, 2'd1);

    // tunnel wrap on the left edge
    mode = 4'b0100; cur_x = 8'd0; cur_y = 8'd14; cur_dir = 2'd1; rom_data = 4'b1000;
    run_move("tunnel", 8'd27, 8'd14, 2'd1);

    // non-one-hot mode behaves as scatter toward (0,0): UP wins at distance 41
    mode = 4'b0011; cur_x = 8'd5; cur_y = 8'd5; cur_dir = 2'd3; rom_data = 4'b1111;
    run_move("mode_fallback", 8'd5, 8'd4, 2'd0);

    // reversal: only opposite(LEFT)=RIGHT may be taken
    mode = 4'b0100; cur_dir = 2'd1; reverse = 1'b1; rom_data = 4'b0100;
    run_move("rev_clear", 8'd6, 8'd5, 2'd3);
    rom_data = 4'b1111;
    run_move("rev_allclear", 8'd6, 8'd5, 2'd3);
    rom_data = 4'b0000;
    run_move("rev_blocked", 8'd5, 8'd5, 2'd1);
    reverse = 1'b0;

    // frightened after reset: LFSR from 16'hACE1, UP excluded by cur_dir DOWN
    resetn = 1'b0;
    @(negedge sysclk);
    resetn = 1'b1;
    mode = 4'b0010; cur_x = 8'd5; cur_y = 8'd5; cur_dir = 2'd2; rom_data = 4'b1111;
    gold = 16'hACE1;
    for (int m = 0; m < 4; m++) begin
      gold = lfsr_step(gold);
      pref = gold[1:0];
      exd  = (pref == 2'd0) ? 2'd1 : pref;
      exx  = 8'd5; exy = 8'd5;
      case (exd)
        2'd1: exx = 8'd4;
        2'd2: exy = 8'd6;
        2'd3: exx = 8'd6;
        default: exy = 8'd4;
      endcase
      run_move($sformatf("fright%0d", m), exx, exy, exd);
    end

    // reset asserted while in DIST: no done, outputs back to reset values
    mode = 4'b0100; cur_dir = 2'd3;
    @(negedge sysclk); start = 1'b1;
    @(negedge sysclk); start = 1'b0;
    repeat (3) @(negedge sysclk);
    resetn = 1'b0;
    @(negedge sysclk);
    resetn = 1'b1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort rom_addr", 32'(rom_addr), 32'd0);
    chk("abort next_x", 32'(next_x), 32'd0);
    chk("abort next_y", 32'(next_y), 32'd0);
    chk("abort next_dir", 32'(next_dir), 32'd1);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sysclk);
      if (done === 1'b1) n_done++;
    end
    chk("abort no_done", 32'(n_done), 32'd0);

    // start while busy is ignored; first request's inputs determine the result
    @(negedge sysclk); start = 1'b1;
    @(negedge sysclk); start = 1'b0;
    @(negedge sysclk);
    start = 1'b1; cur_x = 8'd20; cur_y = 8'd20; cur_dir = 2'd1;
    @(negedge sysclk);
    start = 1'b0;
    n_done = 0; first_k = 0;
    for (int k = 4; k < 16; k++) begin
      @(negedge sysclk);
      if (done === 1'b1) begin
        n_done++;
        if (first_k == 0) begin
          first_k = k;
          chk("busy_start next_x", 32'(next_x), 32'd5);
          chk("busy_start next_y", 32'(next_y), 32'd4);
          chk("busy_start next_dir", 32'(next_dir), 32'd0);
        end
      end
    end
    chk("busy_start done_count", 32'(n_done), 32'd1);
    chk("busy_start latency", 32'(first_k), 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
